// File: rtl/data_sram_req_pkg.sv
// +----------------------------------------------------------------------+
// | data_sram_req_pkg                                                     |
// | Shared mem_op codes, FSM encoding and widths for the data SRAM port.  |
// | Rev 1.0 - initial release                                             |
// +----------------------------------------------------------------------+
`default_nettype none

package data_sram_req_pkg;

   localparam int unsigned c_op_w   = 4;
   localparam int unsigned c_data_w = 32;
   localparam int unsigned c_wen_w  = 4;

   localparam logic [c_op_w-1:0] c_op_none = 4'b0000;
   localparam logic [c_op_w-1:0] c_op_lw   = 4'b1111;
   localparam logic [c_op_w-1:0] c_op_lb   = 4'b0001;
   localparam logic [c_op_w-1:0] c_op_lbu  = 4'b0010;
   localparam logic [c_op_w-1:0] c_op_lh   = 4'b0011;
   localparam logic [c_op_w-1:0] c_op_lhu  = 4'b0100;
   localparam logic [c_op_w-1:0] c_op_sb   = 4'b0101;
   localparam logic [c_op_w-1:0] c_op_sh   = 4'b0110;
   localparam logic [c_op_w-1:0] c_op_sw   = 4'b0111;

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_ISSUE = 1'b1
   } state_t;

   function automatic logic is_load(input logic [c_op_w-1:0] op);
      return (op == c_op_lw) || (op == c_op_lb) || (op == c_op_lbu) ||
             (op == c_op_lh) || (op == c_op_lhu);
   endfunction

   function automatic logic is_misaligned(input logic [c_op_w-1:0] op,
                                          input logic [1:0]        addr_lo);
      logic r;
      r = 1'b0;
      case (op)
         c_op_lh, c_op_lhu, c_op_sh: r = addr_lo[0];
         c_op_lw, c_op_sw:           r = |addr_lo;
         default:                    r = 1'b0;
      endcase
      return r;
   endfunction

endpackage

`default_nettype wire

// File: rtl/data_sram_req_store_lane_gen.sv
// +----------------------------------------------------------------------+
// | store_lane_gen                                                        |
// | Byte-lane write enables, replicated write data and load code.        |
// | Rev 1.0 - initial release                                             |
// +----------------------------------------------------------------------+
`default_nettype none

module store_lane_gen
   import data_sram_req_pkg::*;
(
   input  logic [c_op_w-1:0]   mem_op,
   input  logic [1:0]          addr_lo,
   input  logic [c_data_w-1:0] st_data,
   output logic [c_wen_w-1:0]  wen,
   output logic [c_data_w-1:0] wdata,
   output logic [c_op_w-1:0]   rd_code
);

   // Misaligned halfword/word ops simply ignore the offending low bits.
   always_comb begin
      wen     = 4'b0000;
      wdata   = '0;
      rd_code = mem_op;
      case (mem_op)
         c_op_sb: begin
            wen     = 4'b0001 << addr_lo;
            wdata   = {4{st_data[7:0]}};
            rd_code = c_op_none;
         end
         c_op_sh: begin
            wen     = addr_lo[1] ? 4'b1100 : 4'b0011;
            wdata   = {2{st_data[15:0]}};
            rd_code = c_op_none;
         end
         c_op_sw: begin
            wen     = 4'b1111;
            wdata   = st_data;
            rd_code = c_op_none;
         end
         default: ;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/data_sram_req.sv
// +----------------------------------------------------------------------+
// | data_sram_req                                                         |
// | One-deep request register between EX and the data SRAM port.         |
// | Optional macro MEM_UNALIGN_EXC_EN: trap misaligned ops as exceptions. |
// | Rev 1.0 - initial release                                             |
// +----------------------------------------------------------------------+
`default_nettype none

module data_sram_req
   import data_sram_req_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                flush,
   input  logic                in_valid,
   input  logic [c_op_w-1:0]   mem_op,
   input  logic [ADDR_W-1:0]   mem_addr,
   input  logic [c_data_w-1:0] st_data,
   input  logic                data_sram_ready,
   output logic                in_ready,
   output logic                data_sram_en,
   output logic [c_wen_w-1:0]  data_sram_wen,
   output logic [ADDR_W-1:0]   data_sram_addr,
   output logic [c_data_w-1:0] data_sram_wdata,
   output logic [c_op_w-1:0]   rd_code,
   output logic                stall_req,
   output logic                exc_adel,
   output logic                exc_ades
);

   state_t                r_state;
   state_t                w_state_nxt;
   logic                  w_accept;
   logic                  w_misalign;
   logic                  w_issue;
   logic [c_wen_w-1:0]    w_wen;
   logic [c_data_w-1:0]   w_wdata;
   logic [c_op_w-1:0]     w_rd_code;

   logic                  r_en;
   logic [c_wen_w-1:0]    r_wen;
   logic [ADDR_W-1:0]     r_addr;
   logic [c_data_w-1:0]   r_wdata;
   logic [c_op_w-1:0]     r_rd_code;

   assign in_ready  = (r_state == ST_IDLE) || ((r_state == ST_ISSUE) && data_sram_ready);
   assign stall_req = (r_state == ST_ISSUE) && !data_sram_ready;
   assign w_accept  = in_valid && in_ready && (mem_op != c_op_none) && !flush;
   assign w_issue   = w_accept && !w_misalign;

   store_lane_gen u_lane (
      .mem_op  (mem_op),
      .addr_lo (mem_addr[1:0]),
      .st_data (st_data),
      .wen     (w_wen),
      .wdata   (w_wdata),
      .rd_code (w_rd_code)
   );

   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:  if (w_issue) w_state_nxt = ST_ISSUE;
         ST_ISSUE: if (data_sram_ready) w_state_nxt = w_issue ? ST_ISSUE : ST_IDLE;
         default:  w_state_nxt = ST_IDLE;
      endcase
   end

   // Request fields change only on a new issue or on completion to idle.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_en      <= 1'b0;
         r_wen     <= '0;
         r_addr    <= '0;
         r_wdata   <= '0;
         r_rd_code <= '0;
      end else if (w_issue) begin
         r_en      <= 1'b1;
         r_wen     <= w_wen;
         r_addr    <= {mem_addr[ADDR_W-1:2], 2'b00};
         r_wdata   <= w_wdata;
         r_rd_code <= w_rd_code;
      end else if ((r_state == ST_ISSUE) && data_sram_ready) begin
         r_en      <= 1'b0;
         r_wen     <= '0;
         r_rd_code <= '0;
      end
   end

`ifdef MEM_UNALIGN_EXC_EN
   logic r_exc_adel;
   logic r_exc_ades;

   assign w_misalign = is_misaligned(mem_op, mem_addr[1:0]);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_exc_adel <= 1'b0;
         r_exc_ades <= 1'b0;
      end else begin
         r_exc_adel <= w_accept && w_misalign && is_load(mem_op);
         r_exc_ades <= w_accept && w_misalign && !is_load(mem_op);
      end
   end

   assign exc_adel = r_exc_adel;
   assign exc_ades = r_exc_ades;
`else
   assign w_misalign = 1'b0;
   assign exc_adel   = 1'b0;
   assign exc_ades   = 1'b0;
`endif

   assign data_sram_en    = r_en;
   assign data_sram_wen   = r_wen;
   assign data_sram_addr  = r_addr;
   assign data_sram_wdata = r_wdata;
   assign rd_code         = r_rd_code;

endmodule

`default_nettype wire

// File: tb/tb_data_sram_req.sv
// +----------------------------------------------------------------------+
// | tb_data_sram_req                                                      |
// | Directed self-checking bench for data_sram_req.                       |
// | Rev 1.0 - initial release                                             |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_data_sram_req;

   logic        clk;
   logic        rst;
   logic        flush;
   logic        in_valid;
   logic [3:0]  mem_op;
   logic [31:0] mem_addr;
   logic [31:0] st_data;
   logic        data_sram_ready;
   logic        in_ready;
   logic        data_sram_en;
   logic [3:0]  data_sram_wen;
   logic [31:0] data_sram_addr;
   logic [31:0] data_sram_wdata;
   logic [3:0]  rd_code;
   logic        stall_req;
   logic        exc_adel;
   logic        exc_ades;

   int total;
   int bad;

   data_sram_req #(.ADDR_W(32)) dut (
      .clk             (clk),
      .rst             (rst),
      .flush           (flush),
      .in_valid        (in_valid),
      .mem_op          (mem_op),
      .mem_addr        (mem_addr),
      .st_data         (st_data),
      .data_sram_ready (data_sram_ready),
      .in_ready        (in_ready),
      .data_sram_en    (data_sram_en),
      .data_sram_wen   (data_sram_wen),
      .data_sram_addr  (data_sram_addr),
      .data_sram_wdata (data_sram_wdata),
      .rd_code         (rd_code),
      .stall_req       (stall_req),
      .exc_adel        (exc_adel),
      .exc_ades        (exc_ades)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one clock and settle just after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] d);
      in_valid = v;
      mem_op   = op;
      mem_addr = a;
      st_data  = d;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst = 1'b1;
      flush = 1'b0;
      data_sram_ready = 1'b0;
      drive(1'b0, 4'b0000, 32'h0, 32'h0);
      tick();
      tick();
      rst = 1'b0;
      #1;
      check("rst_in_ready", {31'b0, in_ready}, 32'd1);
      check("rst_stall", {31'b0, stall_req}, 32'd0);
      check("rst_en", {31'b0, data_sram_en}, 32'd0);
      check("rst_wen", {28'b0, data_sram_wen}, 32'h0);
      check("rst_addr", data_sram_addr, 32'h0);
      check("rst_wdata", data_sram_wdata, 32'h0);
      check("rst_rd_code", {28'b0, rd_code}, 32'h0);
      check("rst_exc", {30'b0, exc_adel, exc_ades}, 32'h0);

      // SB to byte 3
      data_sram_ready = 1'b1;
      drive(1'b1, 4'b0101, 32'h0000_1003, 32'h0000_00A5);
      tick();
      drive(1'b0, 4'b0000, 32'h0, 32'h0);
      #1;
      check("sb_en", {31'b0, data_sram_en}, 32'd1);
      check("sb_wen", {28'b0, data_sram_wen}, 32'b1000);
      check("sb_addr", data_sram_addr, 32'h0000_1000);
      check("sb_wdata", data_sram_wdata, 32'hA5A5_A5A5);
      check("sb_rd_code", {28'b0, rd_code}, 32'h0);
      check("sb_stall", {31'b0, stall_req}, 32'd0);
      tick();
      check("sb_idle_en", {31'b0, data_sram_en}, 32'd0);
      check("sb_idle_wen", {28'b0, data_sram_wen}, 32'h0);

      // SB to byte 1
      drive(1'b1, 4'b0101, 32'h0000_1101, 32'h0000_003C);
      tick();
      drive(1'b0, 4'b0000, 32'h0, 32'h0);
      check("sb1_wen", {28'b0, data_sram_wen}, 32'b0010);
      check("sb1_wdata", data_sram_wdata, 32'h3C3C_3C3C);
      tick();

      // LH held by three cycles of backpressure
      data_sram_ready = 1'b0;
      drive(1'b1, 4'b0011, 32'h0000_2002, 32'hFFFF_FFFF);
      tick();
      drive(1'b0, 4'b0000, 32'h0, 32'h0);
      for (int c = 0; c < 3; c++) begin
         #1;
         check("lh_en", {31'b0, data_sram_en}, 32'd1);
         check("lh_wen", {28'b0, data_sram_wen}, 32'h0);
         check("lh_rd_code", {28'b0, rd_code}, 32'b0011);
         check("lh_addr", data_sram_addr, 32'h0000_2000);
         check("lh_wdata", data_sram_wdata, 32'h0);
         check("lh_stall", {31'b0, stall_req}, 32'd1);
         check("lh_in_ready", {31'b0, in_ready}, 32'd0);
         tick();
      end
      data_sram_ready = 1'b1;
      #1;
      check("lh_rel_en", {31'b0, data_sram_en}, 32'd1);
      check("lh_rel_stall", {31'b0, stall_req}, 32'd0);
      check("lh_rel_in_ready", {31'b0, in_ready}, 32'd1);
      tick();
      check("lh_done_en", {31'b0, data_sram_en}, 32'd0);
      check("lh_done_rd_code", {28'b0, rd_code}, 32'h0);

      // SW then LW back-to-back
      drive(1'b1, 4'b0111, 32'h0000_3000, 32'h1234_5678);
      tick();
      drive(1'b1, 4'b1111, 32'h0000_3004, 32'hDEAD_BEEF);
      #1;
      check("b2b_in_ready", {31'b0, in_ready}, 32'd1);
      check("b2b_sw_en", {31'b0, data_sram_en}, 32'd1);
      check("b2b_sw_wen", {28'b0, data_sram_wen}, 32'b1111);
      check("b2b_sw_addr", data_sram_addr, 32'h0000_3000);
      check("b2b_sw_wdata", data_sram_wdata, 32'h1234_5678);
      tick();
      drive(1'b0, 4'b0000, 32'h0, 32'h0);
      #1;
      check("b2b_lw_en", {31'b0, data_sram_en}, 32'd1);
      check("b2b_lw_wen", {28'b0, data_sram_wen}, 32'h0);
      check("b2b_lw_addr", data_sram_addr, 32'h0000_3004);
      check("b2b_lw_wdata", data_sram_wdata, 32'h0);
      check("b2b_lw_rd_code", {28'b0, rd_code}, 32'b1111);
      tick();
      check("b2b_idle_en", {31'b0, data_sram_en}, 32'd0);

      // Misaligned SW
      drive(1'b1, 4'b0111, 32'h0000_4002, 32'hCAFE_F00D);
      tick();
      drive(1'b0, 4'b0000, 32'h0, 32'h0);
`ifdef MEM_UNALIGN_EXC_EN
      check("mis_sw_en", {31'b0, data_sram_en}, 32'd0);
      check("mis_sw_ades", {31'b0, exc_ades}, 32'd1);
      check("mis_sw_adel", {31'b0, exc_adel}, 32'd0);
      tick();
      check("mis_sw_ades_pulse", {31'b0, exc_ades}, 32'd0);
      check("mis_sw_en2", {31'b0, data_sram_en}, 32'd0);
      drive(1'b1, 4'b1111, 32'h0000_5001, 32'h0);
      tick();
      drive(1'b0, 4'b0000, 32'h0, 32'h0);
      check("mis_lw_en", {31'b0, data_sram_en}, 32'd0);
      check("mis_lw_adel", {31'b0, exc_adel}, 32'd1);
      check("mis_lw_ades", {31'b0, exc_ades}, 32'd0);
      tick();
      check("mis_lw_adel_pulse", {31'b0, exc_adel}, 32'd0);
`else
      check("mis_sw_en", {31'b0, data_sram_en}, 32'd1);
      check("mis_sw_wen", {28'b0, data_sram_wen}, 32'b1111);
      check("mis_sw_addr", data_sram_addr, 32'h0000_4000);
      check("mis_sw_ades", {31'b0, exc_ades}, 32'd0);
      tick();
      check("mis_sw_idle_en", {31'b0, data_sram_en}, 32'd0);
`endif

      // Reset while a request is stalled
      data_sram_ready = 1'b0;
      drive(1'b1, 4'b0010, 32'h0000_6001, 32'h0);
      tick();
      drive(1'b0, 4'b0000, 32'h0, 32'h0);
      check("pre_rst_en", {31'b0, data_sram_en}, 32'd1);
      check("pre_rst_stall", {31'b0, stall_req}, 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      check("mid_rst_en", {31'b0, data_sram_en}, 32'd0);
      check("mid_rst_stall", {31'b0, stall_req}, 32'd0);
      check("mid_rst_in_ready", {31'b0, in_ready}, 32'd1);
      check("mid_rst_rd_code", {28'b0, rd_code}, 32'h0);
      check("mid_rst_addr", data_sram_addr, 32'h0);

      // Flush in idle drops the op
      flush = 1'b1;
      drive(1'b1, 4'b0001, 32'h0000_7000, 32'h0);
      tick();
      flush = 1'b0;
      drive(1'b0, 4'b0000, 32'h0, 32'h0);
      check("flush_idle_en", {31'b0, data_sram_en}, 32'd0);
      check("flush_idle_rd_code", {28'b0, rd_code}, 32'h0);

      // Flush during a stalled SH is ignored
      drive(1'b1, 4'b0110, 32'h0000_7002, 32'h0000_BEEF);
      tick();
      drive(1'b0, 4'b0000, 32'h0, 32'h0);
      flush = 1'b1;
      #1;
      check("flush_iss_en", {31'b0, data_sram_en}, 32'd1);
      check("flush_iss_wen", {28'b0, data_sram_wen}, 32'b1100);
      check("flush_iss_wdata", data_sram_wdata, 32'hBEEF_BEEF);
      check("flush_iss_stall", {31'b0, stall_req}, 32'd1);
      tick();
      check("flush_hold_en", {31'b0, data_sram_en}, 32'd1);
      check("flush_hold_wen", {28'b0, data_sram_wen}, 32'b1100);
      check("flush_hold_addr", data_sram_addr, 32'h0000_7000);
      flush = 1'b0;
      data_sram_ready = 1'b1;
      #1;
      check("flush_rel_stall", {31'b0, stall_req}, 32'd0);
      tick();
      check("flush_done_en", {31'b0, data_sram_en}, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
